// File: rtl/fc_mac_accumulator.sv
// Purpose : fully-connected neuron MAC; accumulates N_INPUTS pixel*weight products plus bias, emits one scaled result per neuron.
// Latency : last beat accepted in cycle t -> out_valid in cycle t+2; minimum result period N_INPUTS+2 cycles.
// Backpr. : in_ready drops from the last beat until out_valid&&out_ready; the result is held stable until taken.
// Optional: define FC_MAC_SATURATE_EN to clip the result to OUT_W (out_last_sat flags clipping); otherwise it is truncated.
module fc_mac_accumulator #(
  parameter int N_INPUTS   = 784,
  parameter int IDX_W      = 10,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_pixel,
  input  logic signed [DATA_W-1:0] in_weight,
  input  logic signed [ACC_W-1:0]  bias,
  output logic [IDX_W-1:0]         term_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last_sat
);

  typedef enum logic [1:0] {ST_ACC = 2'd0, ST_DRAIN = 2'd1, ST_OUT = 2'd2} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           term_idx_q, term_idx_d;
  logic signed [ACC_W-1:0]    prod_q, prod_d;
  logic                       prod_vld_q, prod_vld_d;
  logic                       prod_first_q, prod_first_d;
  logic                       prod_last_q, prod_last_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    bias_q, bias_d;
  logic signed [OUT_W-1:0]    out_data_q, out_data_d;

  logic                       accept;
  logic signed [2*DATA_W-1:0] px_ext, wt_ext, mult;
  logic signed [ACC_W-1:0]    sum_now;
  logic signed [ACC_W:0]      wide_sum;
  logic signed [OUT_W-1:0]    res;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign accept    = in_valid && in_ready;
  assign term_idx  = term_idx_q;
  assign out_data  = out_data_q;

  // Operands widened to the full product width so the multiply is exact.
  assign px_ext = {{DATA_W{in_pixel[DATA_W-1]}}, in_pixel};
  assign wt_ext = {{DATA_W{in_weight[DATA_W-1]}}, in_weight};
  assign mult   = px_ext * wt_ext;

  // Next-state logic: ACC until the last term is taken, one drain cycle, then hold the result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC:   if (accept && (term_idx_q == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_ACC;
      default:  state_d = ST_ACC;
    endcase
  end

  // Final sum including the product in flight, then bias add and scaling in ACC_W+1 bits.
`ifdef FC_MAC_SATURATE_EN
  localparam logic signed [ACC_W:0] SAT_MAX = $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN = $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});
  logic signed [ACC_W:0] shifted;
  logic                  res_sat;
  logic                  out_sat_q, out_sat_d;

  always_comb begin
    sum_now  = prod_first_q ? prod_q : acc_q + prod_q;
    wide_sum = {sum_now[ACC_W-1], sum_now} + {bias_q[ACC_W-1], bias_q};
    shifted  = wide_sum >>> FRAC_SHIFT;
    res      = shifted[OUT_W-1:0];
    res_sat  = 1'b0;
    if (shifted > SAT_MAX) begin
      res     = {1'b0, {(OUT_W-1){1'b1}}};
      res_sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res     = {1'b1, {(OUT_W-1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  // Clip flag travels with the captured result.
  always_comb begin
    out_sat_d = out_sat_q;
    if (prod_vld_q && prod_last_q) out_sat_d = res_sat;
  end

  // Clip flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_sat_q <= 1'b0;
    else        out_sat_q <= out_sat_d;
  end

  assign out_last_sat = out_sat_q;
`else
  always_comb begin
    sum_now  = prod_first_q ? prod_q : acc_q + prod_q;
    wide_sum = {sum_now[ACC_W-1], sum_now} + {bias_q[ACC_W-1], bias_q};
    res      = OUT_W'(wide_sum >>> FRAC_SHIFT);
  end

  assign out_last_sat = 1'b0;
`endif

  // Datapath next values: product stage, term counter, bias capture, accumulator, result capture.
  always_comb begin
    term_idx_d   = term_idx_q;
    prod_d       = prod_q;
    prod_vld_d   = accept;
    prod_first_d = prod_first_q;
    prod_last_d  = prod_last_q;
    bias_d       = bias_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    if (accept) begin
      prod_d       = {{(ACC_W-2*DATA_W){mult[2*DATA_W-1]}}, mult};
      prod_first_d = (term_idx_q == '0);
      prod_last_d  = (term_idx_q == LAST_IDX);
      term_idx_d   = (term_idx_q == LAST_IDX) ? '0 : term_idx_q + IDX_W'(1);
      if (term_idx_q == '0) bias_d = bias;
    end
    // First product of a neuron loads rather than adds, so no clear cycle is needed.
    if (prod_vld_q) acc_d = sum_now;
    if (prod_vld_q && prod_last_q) out_data_d = res;
  end

  // State and datapath registers; reset discards any partial sum and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACC;
      term_idx_q   <= '0;
      prod_q       <= '0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_q        <= '0;
      bias_q       <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      term_idx_q   <= term_idx_d;
      prod_q       <= prod_d;
      prod_vld_q   <= prod_vld_d;
      prod_first_q <= prod_first_d;
      prod_last_q  <= prod_last_d;
      acc_q        <= acc_d;
      bias_q       <= bias_d;
      out_data_q   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fc_mac_accumulator.sv
// Bench for fc_mac_accumulator with N_INPUTS=4, FRAC_SHIFT=0.
// Directed scenarios use hand-derived constants; random traffic uses an arithmetic reference model.
module tb_fc_mac_accumulator;
  localparam int N_INPUTS   = 4;
  localparam int IDX_W      = 2;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 16;
  localparam int FRAC_SHIFT = 0;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_pixel = '0;
  logic signed [DATA_W-1:0] in_weight = '0;
  logic signed [ACC_W-1:0]  bias = '0;
  logic [IDX_W-1:0]         term_idx;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_last_sat;

  int tests_run = 0;
  int tests_failed = 0;

  int     px_a [N_INPUTS];
  int     wt_a [N_INPUTS];
  longint bias_a;

  fc_mac_accumulator #(
    .N_INPUTS(N_INPUTS), .IDX_W(IDX_W), .DATA_W(DATA_W),
    .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_weight(in_weight), .bias(bias),
    .term_idx(term_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last_sat(out_last_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of products plus bias, arithmetic shift, then truncate or clip to OUT_W.
  function automatic void model_result(input longint total, output logic signed [OUT_W-1:0] d, output logic s);
    longint v;
    longint vmax;
    longint vmin;
    v    = total >>> FRAC_SHIFT;
    vmax = (64'sd1 <<< (OUT_W - 1)) - 1;
    vmin = -(64'sd1 <<< (OUT_W - 1));
    s    = 1'b0;
`ifdef FC_MAC_SATURATE_EN
    if (v > vmax) begin
      d = OUT_W'(vmax); s = 1'b1;
    end else if (v < vmin) begin
      d = OUT_W'(vmin); s = 1'b1;
    end else begin
      d = OUT_W'(v);
    end
`else
    d = OUT_W'(v);
`endif
  endfunction

  task automatic set_neuron(input int p0, input int p1, input int p2, input int p3,
                            input int w0, input int w1, input int w2, input int w3, input longint b);
    px_a[0] = p0; px_a[1] = p1; px_a[2] = p2; px_a[3] = p3;
    wt_a[0] = w0; wt_a[1] = w1; wt_a[2] = w2; wt_a[3] = w3;
    bias_a  = b;
  endtask

  // Feeds the current neuron; bias carries noise on every beat but term 0.
  task automatic feed_neuron(input int gap_at, input int gap_len);
    int n;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (k == gap_at) begin
        in_valid = 1'b0;
        bias     = ACC_W'($urandom);
        for (int g = 0; g < gap_len; g++) begin
          step();
          tests_run++;
          if (term_idx !== IDX_W'(k)) begin
            tests_failed++;
            $display("FAIL gap_hold: term_idx=%0d required %0d", term_idx, k);
          end
        end
      end
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin step(); n++; end
      tests_run++;
      if (term_idx !== IDX_W'(k) || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL term_seq: term_idx=%0d in_ready=%b required %0d/1", term_idx, in_ready, k);
      end
      in_valid  = 1'b1;
      in_pixel  = DATA_W'(px_a[k]);
      in_weight = DATA_W'(wt_a[k]);
      bias      = (k == 0) ? ACC_W'(bias_a) : ACC_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    bias     = ACC_W'($urandom);
  endtask

  // Waits (bounded) for a result, checks it, and takes it if out_ready is high.
  task automatic expect_result(input string name, input logic signed [OUT_W-1:0] d, input logic s);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end else begin
      tests_run++;
      if (out_data !== d) begin
        tests_failed++;
        $display("FAIL %s_data: out_data=%0d required %0d", name, out_data, d);
      end
      tests_run++;
      if (out_last_sat !== s) begin
        tests_failed++;
        $display("FAIL %s_sat: out_last_sat=%b required %b", name, out_last_sat, s);
      end
    end
    if (out_ready) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (term_idx !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last_sat !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: idx=%0d rdy=%b vld=%b data=%0d sat=%b required 0/1/0/0/0",
               term_idx, in_ready, out_valid, out_data, out_last_sat);
    end
    #4;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_neuron(1, 2, 3, 4, 5, 6, 7, 8, 10);
    out_ready = 1'b1;
    feed_neuron(-1, 0);
    tests_run++;
    if (term_idx !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_drain: idx=%0d rdy=%b vld=%b required 0/0/0", term_idx, in_ready, out_valid);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: out_valid=%b required 1 two cycles after last beat", out_valid);
    end
    expect_result("basic", 16'sd80, 1'b0);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_return: vld=%b rdy=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_gap();
    set_neuron(1, 2, 3, 4, 5, 6, 7, 8, 10);
    feed_neuron(2, 3);
    expect_result("gap", 16'sd80, 1'b0);
  endtask

  task automatic test_backpressure();
    int n = 0;
    set_neuron(1, 2, 3, 4, 5, 6, 7, 8, 10);
    out_ready = 1'b0;
    feed_neuron(-1, 0);
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_pixel = DATA_W'($urandom);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 16'sd80) begin
        tests_failed++;
        $display("FAIL bp_hold: cyc=%0d vld=%b rdy=%b data=%0d required 1/0/80", c, out_valid, in_ready, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    in_pixel  = DATA_W'(px_a[0]);
    in_weight = DATA_W'(wt_a[0]);
    bias      = ACC_W'(bias_a);
    step();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || term_idx !== '0) begin
      tests_failed++;
      $display("FAIL bp_release: vld=%b rdy=%b idx=%0d required 0/1/0", out_valid, in_ready, term_idx);
    end
    feed_neuron(-1, 0);
    expect_result("bp_next", 16'sd80, 1'b0);
  endtask

  task automatic test_saturation();
`ifdef FC_MAC_SATURATE_EN
    logic signed [OUT_W-1:0] d = -16'sd32768;
    logic s = 1'b1;
`else
    logic signed [OUT_W-1:0] d = 16'sd512;
    logic s = 1'b0;
`endif
    set_neuron(-128, -128, -128, -128, 127, 127, 127, 127, 0);
    feed_neuron(-1, 0);
    expect_result("sat", d, s);
  endtask

  task automatic test_reset_mid();
    set_neuron(50, 60, 70, 80, 90, 100, 110, 120, 1000);
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_pixel  = DATA_W'(px_a[k]);
      in_weight = DATA_W'(wt_a[k]);
      bias      = ACC_W'(bias_a);
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (term_idx !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_state: idx=%0d rdy=%b required 0/1", term_idx, in_ready);
    end
    #4;
    rst_n = 1'b1;
    step();
    set_neuron(1, 1, 1, 1, 1, 1, 1, 1, 0);
    feed_neuron(-1, 0);
    expect_result("rst_mid", 16'sd4, 1'b0);
    // Reset while a result is waiting drops it.
    set_neuron(3, 3, 3, 3, 3, 3, 3, 3, 5);
    out_ready = 1'b0;
    feed_neuron(-1, 0);
    step();
    step();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_out_drop: vld=%b data=%0d rdy=%b required 0/0/1", out_valid, out_data, in_ready);
    end
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    set_neuron(1, 2, 3, 4, 5, 6, 7, 8, 10);
    feed_neuron(-1, 0);
    expect_result("b2b_first", 16'sd80, 1'b0);
    set_neuron(1, 2, 3, 4, 5, 6, 7, 8, -10);
    feed_neuron(-1, 0);
    expect_result("b2b_second", 16'sd60, 1'b0);
  endtask

  task automatic test_random();
    int     done = 0;
    int     cycles = 0;
    int     term = 0;
    longint run = 0;
    longint cap = 0;
    logic signed [OUT_W-1:0] d;
    logic   s;
    logic signed [OUT_W-1:0] qd[$];
    logic   qs[$];
    while (done < 24 && cycles < 4000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pixel  = DATA_W'($urandom);
      in_weight = DATA_W'($urandom);
      bias      = ($urandom_range(0, 1) != 0) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 2000)) - 32'sd1000;
      out_ready = ($urandom_range(0, 2) != 0);
      if (term_idx !== IDX_W'(term)) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rand_term: term_idx=%0d required %0d", term_idx, term);
      end
      if (in_valid && in_ready) begin
        if (term == 0) begin
          cap = longint'(bias);
          run = 0;
        end
        run += longint'(in_pixel) * longint'(in_weight);
        term++;
        if (term == N_INPUTS) begin
          model_result(run + cap, d, s);
          qd.push_back(d);
          qs.push_back(s);
          term = 0;
        end
      end
      if (out_valid && out_ready) begin
        tests_run++;
        if (qd.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_extra: out_data=%0d required no result", out_data);
        end else begin
          d = qd.pop_front();
          s = qs.pop_front();
          if (out_data !== d || out_last_sat !== s) begin
            tests_failed++;
            $display("FAIL rand_result: data=%0d sat=%b required %0d/%b", out_data, out_last_sat, d, s);
          end
        end
        done++;
      end
      step();
      cycles++;
    end
    tests_run++;
    if (done < 24) begin
      tests_failed++;
      $display("FAIL rand_timeout: results=%0d required 24", done);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    do_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
